// File: rtl/bcd_to_bin_serial_if.sv
// ============================================================================
// bcd_to_bin_serial_if
//   Start/done handshake and data bundle for the serial BCD-to-binary converter.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface bcd_to_bin_serial_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      bin_out;

  modport master (
    output start, bcd_in,
    input  busy, done, err, bin_out
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, err, bin_out
  );
endinterface

`default_nettype wire

// File: rtl/bcd_to_bin_serial.sv
// ============================================================================
// bcd_to_bin_serial
//   Packed BCD to binary by reverse double-dabble: one shift-right/subtract-3 per clock.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bcd_to_bin_serial #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  wire                    Clock,
  input  wire                    Reset,
  bcd_to_bin_serial_if.slave     bus
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [SR_W-1:0]     sr;
  logic [CNT_W-1:0]    count;
  logic                err_next;

  logic [SR_W-1:0]     sr_shifted;
  logic                bad_digit;

  // Shift first, then pull each decimal field back by 3 if the incoming bit made it >= 8.
  always_comb begin
    sr_shifted = sr >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_shifted[BIN_W + 4*d +: 4] >= 4'd8)
        sr_shifted[BIN_W + 4*d +: 4] = sr_shifted[BIN_W + 4*d +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.bcd_in[4*d +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      sr          <= '0;
      count       <= '0;
      err_next    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.bin_out <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bad_digit) begin
              err_next <= 1'b1;
              sr       <= '0;
              state    <= DONE;
            end else begin
              err_next <= 1'b0;
              sr       <= {bus.bcd_in, {BIN_W{1'b0}}};
              count    <= CNT_W'(BIN_W);
              state    <= SHIFT;
            end
          end
        end

        SHIFT: begin
          sr    <= sr_shifted;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1))
            state <= DONE;
        end

        DONE: begin
          bus.done    <= 1'b1;
          bus.err     <= err_next;
          bus.bin_out <= err_next ? '0 : sr[BIN_W-1:0];
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_serial.sv
// ============================================================================
// tb_bcd_to_bin_serial
//   Directed self-checking bench for the serial BCD-to-binary converter.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_to_bin_serial;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_to_bin_serial_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_serial #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered #1 after a rising edge; returns #1 after the edge that raised done.
  task automatic conv(input string tag, input logic [7:0] bcd, input logic [6:0] exp_bin,
                      input logic exp_err, input int exp_lat, output int done_cyc);
    int         n;
    int         busy_cnt;
    logic       stable;
    logic [6:0] prev_bin;
    logic       prev_err;
    prev_bin   = bus.bin_out;
    prev_err   = bus.err;
    stable     = 1'b1;
    busy_cnt   = 0;
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bcd_in = ~bcd;
    n = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) busy_cnt++;
      if (bus.bin_out !== prev_bin || bus.err !== prev_err) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"},    {31'd0, bus.done}, 32'd1);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_bin"},     {25'd0, bus.bin_out}, {25'd0, exp_bin});
    check({tag, "_err"},     {31'd0, bus.err}, {31'd0, exp_err});
    check({tag, "_stable"},  {31'd0, stable}, 32'd1);
    check({tag, "_busy"},    busy_cnt, exp_lat);
    done_cyc = cyc;
  endtask

  initial begin
    int       t;
    int       t_prev;
    int       dones;
    logic [6:0] seen_bin;
    logic [7:0] code;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_err",  {31'd0, bus.err},  32'd0);
    check("reset_bin",  {25'd0, bus.bin_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic conversions, including the extremes of the valid range
    conv("c47", 8'h47, 7'd47, 1'b0, BIN_W + 1, t);
    conv("c99", 8'h99, 7'd99, 1'b0, BIN_W + 1, t);
    conv("c00", 8'h00, 7'd0,  1'b0, BIN_W + 1, t);

    // Invalid tens digit short-circuits to DONE; next valid request clears err
    conv("cA5", 8'hA5, 7'd0,  1'b1, 1, t);
    conv("c12", 8'h12, 7'd12, 1'b0, BIN_W + 1, t);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("bin_hold", {25'd0, bus.bin_out}, 32'd12);

    // Starts while busy are ignored
    bus.start  = 1'b1;
    bus.bcd_in = 8'h35;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.bcd_in = 8'h80;
    dones      = 0;
    seen_bin   = '0;
    repeat (5) @(posedge clk);
    #1;
    bus.start  = 1'b0;
    repeat (15) begin
      if (bus.done) begin
        dones++;
        seen_bin = bus.bin_out;
      end
      @(posedge clk); #1;
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_bin", {25'd0, seen_bin}, 32'd35);

    // Reset during SHIFT aborts the conversion
    bus.start  = 1'b1;
    bus.bcd_in = 8'h63;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_bin",  {25'd0, bus.bin_out}, 32'd0);
    check("abort_err",  {31'd0, bus.err}, 32'd0);
    @(posedge clk); #1;
    rst   = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);
    conv("c63", 8'h63, 7'd63, 1'b0, BIN_W + 1, t);

    // Full sweep back-to-back; done spacing must be BIN_W+2
    t_prev = 0;
    for (int i = 0; i < 100; i++) begin
      code = {4'(i / 10), 4'(i % 10)};
      conv("sweep", code, 7'(i), 1'b0, BIN_W + 1, t);
      if (i > 0) check("sweep_spacing", t - t_prev, BIN_W + 2);
      t_prev = t;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
